// File: rtl/lookup_pkg.sv
// lookup_pkg: shared command encodings, key split constants and sequencer states
package lookup_pkg;
    localparam logic [1:0] CMD_KEY        = 2'd0;
    localparam logic [1:0] CMD_ACT        = 2'd1;
    localparam logic [1:0] CMD_KEY_ACT    = 2'd2;
    localparam logic [1:0] CMD_RSV        = 2'd3;
    localparam logic [24:0] DEFAULT_ACTION = 25'h3f;
    localparam int CAM0_LSB   = 384;
    localparam int CAM1_KEY_W = 384;
    typedef enum logic [2:0] {IDLE, DRAIN, WR_CAM, WAIT_BUSY, WR_ACT, DONE} state_t;
endpackage

// File: rtl/lookup_key_splitter.sv
// lookup_key_splitter: maps a full key/mask plus cond flag onto the two CAM slices
module lookup_key_splitter
    import lookup_pkg::*;
#(
    parameter int KEY_LEN = 896,
    parameter int CAM0_W  = 512,
    parameter int CAM1_W  = 385
) (
    input  logic [KEY_LEN-1:0] key,
    input  logic [KEY_LEN-1:0] mask,
    input  logic               cond,
    output logic [CAM0_W-1:0]  cam0_din,
    output logic [CAM0_W-1:0]  cam0_mask,
    output logic [CAM1_W-1:0]  cam1_din,
    output logic [CAM1_W-1:0]  cam1_mask
);
    assign cam0_din  = key[KEY_LEN-1:CAM0_LSB];
    assign cam0_mask = mask[KEY_LEN-1:CAM0_LSB];
    // cond always sits in the LSB of cam1 and is never wildcarded
    assign cam1_din  = {key[CAM1_KEY_W-1:0], cond};
    assign cam1_mask = {mask[CAM1_KEY_W-1:0], 1'b0};
endmodule

// File: rtl/lookup_cfg_ctrl.sv
// lookup_cfg_ctrl: sequences table-update commands into the CAM slices and action RAM
module lookup_cfg_ctrl
    import lookup_pkg::*;
#(
    parameter int         KEY_LEN      = 896,
    parameter int         CAM0_W       = 512,
    parameter int         CAM1_W       = 385,
    parameter int         ACT_W        = 25,
    parameter int         ADDR_W       = 4,
    parameter logic [3:0] STAGE        = 4'd0,
    parameter int         BUSY_TIMEOUT = 64
) (
    input  logic               axis_clk,
    input  logic               aresetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_stage,
    input  logic [1:0]         cmd_type,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [KEY_LEN-1:0] cmd_key,
    input  logic [KEY_LEN-1:0] cmd_mask,
    input  logic               cmd_cond,
    input  logic [ACT_W-1:0]   cmd_action,
    input  logic               lookup_idle,
    output logic               lookup_hold,
    output logic               cam0_we,
    output logic               cam1_we,
    output logic [ADDR_W-1:0]  cam0_wr_addr,
    output logic [ADDR_W-1:0]  cam1_wr_addr,
    output logic [CAM0_W-1:0]  cam0_din,
    output logic [CAM0_W-1:0]  cam0_mask,
    output logic [CAM1_W-1:0]  cam1_din,
    output logic [CAM1_W-1:0]  cam1_mask,
    input  logic               cam0_busy,
    input  logic               cam1_busy,
    output logic               act_we,
    output logic [ADDR_W-1:0]  act_addr,
    output logic [ACT_W-1:0]   act_din,
    output logic               done,
    output logic               err,
    output logic [15:0]        wr_count
);
    localparam int TO_W = $clog2(BUSY_TIMEOUT) + 1;

    state_t              state, state_nx;
    logic [1:0]          type_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [KEY_LEN-1:0]  key_q, mask_q;
    logic                cond_q;
    logic [ACT_W-1:0]    action_q;
    logic [TO_W-1:0]     to_cnt;
    logic                err_q;
    logic [15:0]         cnt_q;
    logic                accept, hit, busy, timeout, cam_we;

    assign accept  = cmd_valid && cmd_ready;
    assign hit     = accept && cmd_stage == STAGE;
    assign busy    = cam0_busy || cam1_busy;
    assign timeout = state == WAIT_BUSY && busy && to_cnt == TO_W'(BUSY_TIMEOUT - 1);

    lookup_key_splitter #(.KEY_LEN(KEY_LEN), .CAM0_W(CAM0_W), .CAM1_W(CAM1_W)) u_split (
        .key       (key_q),
        .mask      (mask_q),
        .cond      (cond_q),
        .cam0_din  (cam0_din),
        .cam0_mask (cam0_mask),
        .cam1_din  (cam1_din),
        .cam1_mask (cam1_mask)
    );

    // State register; reset aborts any in-flight update immediately
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nx;
    end

    // Capture command fields on accept so the parser may move on
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            type_q   <= '0;
            addr_q   <= '0;
            key_q    <= '0;
            mask_q   <= '0;
            cond_q   <= 1'b0;
            action_q <= '0;
        end else if (accept) begin
            type_q   <= cmd_type;
            addr_q   <= cmd_addr;
            key_q    <= cmd_key;
            mask_q   <= cmd_mask;
            cond_q   <= cmd_cond;
            action_q <= cmd_action;
        end
    end

    // Busy timeout counter, error pulse and saturating completion count
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            to_cnt <= state == WAIT_BUSY ? to_cnt + 1'b1 : '0;
            err_q  <= timeout || (hit && cmd_type == CMD_RSV);
            cnt_q  <= state == DONE && cnt_q != 16'hFFFF ? cnt_q + 16'd1 : cnt_q;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = hit && cmd_type != CMD_RSV ? DRAIN : IDLE;
            DRAIN:     state_nx = !lookup_idle ? DRAIN : type_q == CMD_ACT ? WR_ACT : WR_CAM;
            WR_CAM:    state_nx = WAIT_BUSY;
            WAIT_BUSY: state_nx = !busy ? (type_q == CMD_KEY_ACT ? WR_ACT : DONE) : timeout ? DONE : WAIT_BUSY;
            WR_ACT:    state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Moore outputs; err_q is only high in DONE when the busy wait timed out
    always_comb begin
        cmd_ready   = aresetn && state == IDLE;
        lookup_hold = state inside {DRAIN, WR_CAM, WAIT_BUSY, WR_ACT};
        cam_we      = state == WR_CAM;
        act_we      = state == WR_ACT;
        done        = state == DONE && !err_q;
    end

    assign cam0_we      = cam_we;
    assign cam1_we      = cam_we;
    assign cam0_wr_addr = addr_q;
    assign cam1_wr_addr = addr_q;
    assign act_addr     = addr_q;
    assign act_din      = action_q;
    assign err          = err_q;
    assign wr_count     = cnt_q;
endmodule

// File: tb/tb_lookup_cfg_ctrl.sv
// tb_lookup_cfg_ctrl: directed checks of the lookup table update sequencer
module tb_lookup_cfg_ctrl;
    logic         axis_clk = 1'b0;
    logic         aresetn  = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_stage = '0;
    logic [1:0]   cmd_type = '0;
    logic [3:0]   cmd_addr = '0;
    logic [895:0] cmd_key = '0;
    logic [895:0] cmd_mask = '0;
    logic         cmd_cond = 1'b0;
    logic [24:0]  cmd_action = '0;
    logic         lookup_idle = 1'b1;
    logic         lookup_hold;
    logic         cam0_we, cam1_we;
    logic [3:0]   cam0_wr_addr, cam1_wr_addr;
    logic [511:0] cam0_din, cam0_mask;
    logic [384:0] cam1_din, cam1_mask;
    logic         cam0_busy = 1'b0;
    logic         cam1_busy = 1'b0;
    logic         act_we;
    logic [3:0]   act_addr;
    logic [24:0]  act_din;
    logic         done, err;
    logic [15:0]  wr_count;

    int checks = 0;
    int errors = 0;

    logic [895:0] k, m;
    logic         seen;

    lookup_cfg_ctrl dut (
        .axis_clk(axis_clk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_stage(cmd_stage),
        .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_key(cmd_key),
        .cmd_mask(cmd_mask), .cmd_cond(cmd_cond), .cmd_action(cmd_action),
        .lookup_idle(lookup_idle), .lookup_hold(lookup_hold),
        .cam0_we(cam0_we), .cam1_we(cam1_we),
        .cam0_wr_addr(cam0_wr_addr), .cam1_wr_addr(cam1_wr_addr),
        .cam0_din(cam0_din), .cam0_mask(cam0_mask),
        .cam1_din(cam1_din), .cam1_mask(cam1_mask),
        .cam0_busy(cam0_busy), .cam1_busy(cam1_busy),
        .act_we(act_we), .act_addr(act_addr), .act_din(act_din),
        .done(done), .err(err), .wr_count(wr_count)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic send(input logic [3:0] stage, input logic [1:0] typ, input logic [3:0] addr, input logic [24:0] act);
        cmd_stage  = stage;
        cmd_type   = typ;
        cmd_addr   = addr;
        cmd_action = act;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
        cmd_addr   = ~addr;
        cmd_action = ~act;
        cmd_key    = ~cmd_key;
        cmd_mask   = ~cmd_mask;
        cmd_cond   = ~cmd_cond;
    endtask

    initial begin
        tick();
        tick();
        check("rst_ready", cmd_ready, 0);
        check("rst_hold", lookup_hold, 0);
        check("rst_cam_we", cam0_we | cam1_we, 0);
        check("rst_act_we", act_we, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_wr_count", wr_count, 0);
        aresetn = 1'b1;
        tick();
        check("idle_ready", cmd_ready, 1);

        // key+action write, everything ready immediately
        k = {{64{8'hAA}}, {48{8'h5C}}};
        m = {{64{8'h0F}}, {48{8'hF0}}};
        cmd_key  = k;
        cmd_mask = m;
        cmd_cond = 1'b1;
        send(4'd0, 2'd2, 4'd5, 25'h1234);
        check("t2_c1_hold", lookup_hold, 1);
        check("t2_c1_ready", cmd_ready, 0);
        check("t2_c1_cam_we", cam0_we, 0);
        tick();
        check("t2_c2_cam_we", {cam0_we, cam1_we}, 2'b11);
        check("t2_c2_addr", {cam0_wr_addr, cam1_wr_addr}, 8'h55);
        check("t2_cam0_din", cam0_din == k[895:384], 1);
        check("t2_cam0_mask", cam0_mask == m[895:384], 1);
        check("t2_cam1_din", cam1_din == {k[383:0], 1'b1}, 1);
        check("t2_cam1_mask", cam1_mask == {m[383:0], 1'b0}, 1);
        check("t2_cam0_din_lo", cam0_din[63:0], 64'hAAAAAAAAAAAAAAAA);
        check("t2_cam1_din_lo", cam1_din[7:0], 8'hB9);
        check("t2_cam1_mask_lo", cam1_mask[7:0], 8'hE0);
        check("t2_c2_act_we", act_we, 0);
        tick();
        check("t2_c3_strobes", {cam0_we, cam1_we, act_we}, 0);
        check("t2_c3_hold", lookup_hold, 1);
        tick();
        check("t2_c4_act_we", act_we, 1);
        check("t2_c4_act_addr", act_addr, 4'd5);
        check("t2_c4_act_din", act_din, 25'h1234);
        check("t2_c4_cam_we", cam1_we, 0);
        tick();
        check("t2_c5_done", done, 1);
        check("t2_c5_hold", lookup_hold, 0);
        check("t2_c5_err", err, 0);
        tick();
        check("t2_after_done", done, 0);
        check("t2_wr_count", wr_count, 1);
        check("t2_after_ready", cmd_ready, 1);

        // action only, lookups still in flight for 10 cycles
        lookup_idle = 1'b0;
        send(4'd0, 2'd1, 4'd9, 25'h1ABCDE);
        check("t1_hold_c1", lookup_hold, 1);
        seen = 1'b0;
        repeat (9) begin
            tick();
            seen |= act_we | !lookup_hold | done;
        end
        check("t1_drain_held", seen, 0);
        lookup_idle = 1'b1;
        tick();
        check("t1_act_we", act_we, 1);
        check("t1_act_addr", act_addr, 4'd9);
        check("t1_act_din", act_din, 25'h1ABCDE);
        tick();
        check("t1_done", done, 1);
        tick();
        check("t1_wr_count", wr_count, 2);

        // key only, cam1 busy for 7 cycles after the write strobe
        send(4'd0, 2'd0, 4'd3, 25'h0);
        tick();
        check("t0_cam_we", {cam0_we, cam1_we}, 2'b11);
        check("t0_cam_addr", cam1_wr_addr, 4'd3);
        cam1_busy = 1'b1;
        seen = 1'b0;
        repeat (7) begin
            tick();
            seen |= done | act_we | !lookup_hold;
        end
        check("t0_busy_wait", seen, 0);
        cam1_busy = 1'b0;
        tick();
        check("t0_done", done, 1);
        check("t0_no_act", act_we, 0);
        tick();
        check("t0_wr_count", wr_count, 3);

        // key only, cam0 busy stuck: timeout
        send(4'd0, 2'd0, 4'd7, 25'h0);
        tick();
        cam0_busy = 1'b1;
        tick();
        seen = 1'b0;
        repeat (63) begin
            tick();
            seen |= err | done;
        end
        check("to_early", seen, 0);
        check("to_hold_c63", lookup_hold, 1);
        tick();
        check("to_err", err, 1);
        check("to_done", done, 0);
        check("to_hold", lookup_hold, 0);
        tick();
        check("to_err_pulse", err, 0);
        check("to_ready", cmd_ready, 1);
        cam0_busy = 1'b0;

        // foreign stage dropped, reserved type flagged
        send(4'd3, 2'd0, 4'd1, 25'h0);
        check("st_hold", lookup_hold, 0);
        check("st_ready", cmd_ready, 1);
        tick();
        check("st_quiet", {err, done, cam0_we, act_we, lookup_hold}, 0);
        send(4'd0, 2'd3, 4'd1, 25'h0);
        check("rsv_err", err, 1);
        check("rsv_hold", lookup_hold, 0);
        check("rsv_ready", cmd_ready, 1);
        tick();
        check("rsv_err_pulse", err, 0);
        check("rsv_no_strobe", {cam0_we, act_we, done}, 0);

        // reset during WAIT_BUSY, then a fresh action write
        send(4'd0, 2'd0, 4'd2, 25'h0);
        tick();
        cam0_busy = 1'b1;
        tick();
        tick();
        check("ar_hold_before", lookup_hold, 1);
        #2;
        aresetn = 1'b0;
        #1;
        check("ar_hold", lookup_hold, 0);
        check("ar_strobes", {cam0_we, cam1_we, act_we}, 0);
        check("ar_ready", cmd_ready, 0);
        tick();
        check("ar_wr_count", wr_count, 0);
        aresetn   = 1'b1;
        cam0_busy = 1'b0;
        send(4'd0, 2'd1, 4'd4, 25'h0F0F0);
        check("ar_t1_hold", lookup_hold, 1);
        tick();
        check("ar_t1_act_we", act_we, 1);
        check("ar_t1_act_din", act_din, 25'h0F0F0);
        tick();
        check("ar_t1_done", done, 1);
        tick();
        check("ar_t1_wr_count", wr_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lookup_cfg_ctrl.md
Name: lookup_cfg_ctrl

Overview:
- Control-plane sequencer for one pipeline stage's lookup engine.
- Accepts table-update commands and gates new lookups while it updates.
- Splits each 896b key/mask into the 512b CAM slice (cam0) and the 385b CAM slice (cam1, including cond_flag), waits for CAM BUSY to clear, then writes the 25b action RAM entry.
- Sits between the control-channel parser and lookup_engine write ports.

Parameters:
- KEY_LEN, 896, extracted key width
- CAM0_W, 512, cam0 width; carries key[895:384]
- CAM1_W, 385, cam1 width; carries {key[383:0], cond}
- ACT_W, 25, action word width
- ADDR_W, 4, table address width (16 entries)
- STAGE, 0, stage ID this instance answers to
- BUSY_TIMEOUT, 64, max cycles to wait for CAM BUSY to clear

Ports:
- axis_clk  in  1  clock
- aresetn  in  1  async active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_stage  in  4  target stage ID
- cmd_type  in  2  0=key only, 1=action only, 2=key+action, 3=reserved
- cmd_addr  in  ADDR_W  entry index
- cmd_key  in  KEY_LEN  key data
- cmd_mask  in  KEY_LEN  key mask (1=don't care)
- cmd_cond  in  1  cond_flag match value
- cmd_action  in  ACT_W  action word
- lookup_idle  in  1  lookup_engine has no lookup in flight
- lookup_hold  out  1  block new key_valid into lookup_engine
- cam0_we / cam1_we  out  1  CAM write strobes
- cam0_wr_addr / cam1_wr_addr  out  ADDR_W  CAM write address
- cam0_din, cam0_mask  out  CAM0_W  cam0 data/mask
- cam1_din, cam1_mask  out  CAM1_W  cam1 data/mask
- cam0_busy / cam1_busy  in  1  CAM internal write in progress
- act_we  out  1  action RAM write enable
- act_addr  out  ADDR_W  action RAM address
- act_din  out  ACT_W  action RAM data
- done  out  1  one-cycle pulse, command completed
- err  out  1  one-cycle pulse, reserved type or busy timeout
- wr_count  out  16  completed writes, saturating

Behaviour:
- Reset: all outputs 0 except cmd_ready=0. FSM=IDLE, counters 0. Asserting reset mid-operation aborts immediately: strobes and lookup_hold drop asynchronously, and the partial write is not retried.
- cmd_ready=1 only in IDLE. Command fields are registered on accept and are don't-care afterwards.
- FSM states: IDLE, DRAIN, WR_CAM, WAIT_BUSY, WR_ACT, DONE.
- IDLE, accept with cmd_stage!=STAGE: command is dropped silently, stay in IDLE, no hold, no done.
- IDLE, accept with type=3: err pulses next cycle, stay in IDLE.
- IDLE, accept with a valid type: lookup_hold=1 from the next cycle, go to DRAIN.
- DRAIN: wait for lookup_idle=1. Then type 0/2 -> WR_CAM; type 1 -> WR_ACT. If lookup_idle=1 on the first DRAIN cycle, leave after exactly one cycle.
- WR_CAM: exactly one cycle; cam0_we=cam1_we=1, both addresses=cmd_addr.
  - cam0_din=key[895:384], cam0_mask=mask[895:384]
  - cam1_din={key[383:0],cond}, cam1_mask={mask[383:0],1'b0}; cond is always exact-match.
  - Go to WAIT_BUSY.
- WAIT_BUSY: the first cycle always waits, because BUSY lags WE by one cycle. Leave when cam0_busy=cam1_busy=0: type 2 -> WR_ACT, type 0 -> DONE. Timeout counter starts at entry; at BUSY_TIMEOUT cycles, err pulses and FSM goes to DONE with done suppressed.
- WR_ACT: one cycle; act_we=1, act_addr=cmd_addr, act_din=cmd_action. Go to DONE.
- DONE: one cycle; done=1 (unless timeout), wr_count+=1 saturating at 16'hFFFF, lookup_hold=0 in this same cycle, next state IDLE.
- Minimum latency, accept to done, with busy clearing immediately:
  - type 1: 3 cycles
  - type 0: 4 cycles
  - type 2: 5 cycles
- Strobes are never asserted outside their own states; cam0_we and cam1_we are always simultaneous.
- cmd_valid held high across commands: the next accept happens in the cycle after DONE (IDLE). There is no back-to-back accept.

Decomposition:
- Shared package lookup_pkg holds:
  - cmd_type encodings CMD_KEY=0, CMD_ACT=1, CMD_KEY_ACT=2
  - DEFAULT_ACTION=25'h3f
  - key split constants CAM0_LSB=384, CAM1_KEY_W=384
  - FSM state typedef
- One natural sub-module: lookup_key_splitter, purely combinational, mapping key/mask/cond to the cam0/cam1 din/mask buses. It is reused by the engine's compare-side key mapping.
- Timeout counter and FSM stay inline.

Test Plan:
- type=2, addr=5, key[895:384]=all-A, cond=1, action=25'h1234, busy low, lookup_idle=1 -> cam*_we pulse at cycle 2; act_we with act_din=25'h1234 at cycle 4; done at cycle 5; wr_count=1.
- lookup_idle held 0 for 10 cycles after accept, type 1 -> lookup_hold=1 throughout, no act_we until the cycle after lookup_idle rises, then done one cycle later.
- type 0, cam1_busy held 1 for 7 cycles after WE -> no done until busy clears, then done; act_we never asserts.
- type 0, cam0_busy stuck 1 -> err pulse exactly 64 cycles after WAIT_BUSY entry, done=0, FSM returns to IDLE, cmd_ready=1.
- cmd_stage=3 with STAGE=0, then type=3 -> no strobes, no hold; err pulse only for the type=3 command.
- aresetn asserted during WAIT_BUSY -> lookup_hold and all strobes 0 immediately; after release, a new type-1 command completes in 3 cycles.
